// File: rtl/parking_gate_if.sv
// Gate request/response channel between the gate front-ends and the occupancy controller.
// The master side raises requests; the slave side grants them and answers one cycle later.
interface parking_gate_if #(
  parameter int NUM_GATES = 2,
  parameter int GW        = 1
) ();
  logic [NUM_GATES-1:0] req_valid;
  logic [NUM_GATES-1:0] req_entry;
  logic [NUM_GATES-1:0] req_uni;
  logic [NUM_GATES-1:0] req_ready;
  logic                 resp_valid;
  logic [GW-1:0]        resp_gate;
  logic                 resp_ok;

  modport master (
    output req_valid, req_entry, req_uni,
    input  req_ready, resp_valid, resp_gate, resp_ok
  );

  modport slave (
    input  req_valid, req_entry, req_uni,
    output req_ready, resp_valid, resp_gate, resp_ok
  );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Multi-gate parking occupancy controller: a round-robin arbiter grants one gate request per cycle.
// Each request is decided against the uni reservation, which follows an hourly schedule.
module parking_gate_ctrl #(
  parameter int NUM_GATES       = 2,
  parameter int TOTAL_SPACE     = 10,
  parameter int INIT_UNI_SPACE  = 5,
  parameter int FINAL_UNI_SPACE = 2,
  parameter int INCREMENT       = 1,
  parameter int SHRINK_START    = 13,
  parameter int RESET_HOUR      = 0,
  localparam int CNT_W = $clog2(TOTAL_SPACE + 1),
  localparam int GW    = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hour_tick_i,
  parking_gate_if.slave    gate_if,
  output logic [4:0]       hour_o,
  output logic [CNT_W-1:0] uni_cap_o,
  output logic [CNT_W-1:0] uni_parked_o,
  output logic [CNT_W-1:0] gen_parked_o,
  output logic [CNT_W-1:0] uni_free_o,
  output logic [CNT_W-1:0] gen_free_o,
  output logic             uni_avail_o,
  output logic             gen_avail_o
);

  localparam int SW = CNT_W + 2;

  logic [4:0]       hour_q, hour_d, hourNext;
  logic [CNT_W-1:0] uniCap_q, uniCap_d;
  logic [CNT_W-1:0] uniParked_q, uniParked_d;
  logic [CNT_W-1:0] nonuniParked_q, nonuniParked_d;
  logic [CNT_W-1:0] uniOvf_q, uniOvf_d;
  logic [GW-1:0]    rrPtr_q, rrPtr_d;
  logic             respValid_q, respValid_d;
  logic [GW-1:0]    respGate_q, respGate_d;
  logic             respOk_q, respOk_d;

  logic [GW-1:0]    grantIdx;
  logic             grantFound;
  int               arbIdx;
  logic             selEntry, selUni;
  logic [CNT_W-1:0] uniFree, genFree;
  logic [SW-1:0]    genParkedW, usedW;

  // Stranded uni cars above a shrunk reservation eat into general space via the max().
  assign genParkedW = SW'(nonuniParked_q) + SW'(uniOvf_q);
  assign usedW      = ((uniCap_q > uniParked_q) ? SW'(uniCap_q) : SW'(uniParked_q)) + genParkedW;
  assign uniFree    = (uniCap_q > uniParked_q) ? uniCap_q - uniParked_q : '0;
  assign genFree    = (usedW < SW'(TOTAL_SPACE)) ? CNT_W'(SW'(TOTAL_SPACE) - usedW) : '0;

  always_comb begin
    grantFound        = 1'b0;
    grantIdx          = '0;
    arbIdx            = 0;
    gate_if.req_ready = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      arbIdx = (int'(rrPtr_q) + i) % NUM_GATES;
      if (!grantFound && gate_if.req_valid[arbIdx]) begin
        grantFound = 1'b1;
        grantIdx   = GW'(arbIdx);
      end
    end
    if (grantFound) gate_if.req_ready[grantIdx] = 1'b1;
  end

  assign selEntry = gate_if.req_entry[grantIdx];
  assign selUni   = gate_if.req_uni[grantIdx];
  assign hourNext = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;

  always_comb begin
    hour_d         = hour_q;
    uniCap_d       = uniCap_q;
    uniParked_d    = uniParked_q;
    nonuniParked_d = nonuniParked_q;
    uniOvf_d       = uniOvf_q;
    rrPtr_d        = rrPtr_q;
    respValid_d    = grantFound;
    respGate_d     = grantFound ? grantIdx : respGate_q;
    respOk_d       = 1'b0;

    if (grantFound) begin
      rrPtr_d = (grantIdx == GW'(NUM_GATES - 1)) ? '0 : grantIdx + GW'(1);
      unique case ({selEntry, selUni})
        2'b11: begin
          if (uniFree != '0) begin
            uniParked_d = uniParked_q + CNT_W'(1);
            respOk_d    = 1'b1;
          end else if (genFree != '0) begin
            uniOvf_d = uniOvf_q + CNT_W'(1);
            respOk_d = 1'b1;
          end
        end
        2'b10: begin
          if (genFree != '0) begin
            nonuniParked_d = nonuniParked_q + CNT_W'(1);
            respOk_d       = 1'b1;
          end
        end
        2'b01: begin
          if (uniOvf_q != '0) begin
            uniOvf_d = uniOvf_q - CNT_W'(1);
            respOk_d = 1'b1;
          end else if (uniParked_q != '0) begin
            uniParked_d = uniParked_q - CNT_W'(1);
            respOk_d    = 1'b1;
          end
        end
        default: begin
          if (nonuniParked_q != '0) begin
            nonuniParked_d = nonuniParked_q - CNT_W'(1);
            respOk_d       = 1'b1;
          end
        end
      endcase
    end

    // The decision above saw the pre-tick reservation; the new one lands on the same edge.
    if (hour_tick_i) begin
      hour_d = hourNext;
      if (hourNext == 5'd0) begin
        uniCap_d = CNT_W'(INIT_UNI_SPACE);
      end else if (int'(hourNext) > SHRINK_START) begin
        uniCap_d = (int'(uniCap_q) >= FINAL_UNI_SPACE + INCREMENT) ?
                   uniCap_q - CNT_W'(INCREMENT) : CNT_W'(FINAL_UNI_SPACE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_q         <= 5'(RESET_HOUR);
      uniCap_q       <= CNT_W'(INIT_UNI_SPACE);
      uniParked_q    <= '0;
      nonuniParked_q <= '0;
      uniOvf_q       <= '0;
      rrPtr_q        <= '0;
      respValid_q    <= 1'b0;
      respGate_q     <= '0;
      respOk_q       <= 1'b0;
    end else begin
      hour_q         <= hour_d;
      uniCap_q       <= uniCap_d;
      uniParked_q    <= uniParked_d;
      nonuniParked_q <= nonuniParked_d;
      uniOvf_q       <= uniOvf_d;
      rrPtr_q        <= rrPtr_d;
      respValid_q    <= respValid_d;
      respGate_q     <= respGate_d;
      respOk_q       <= respOk_d;
    end
  end

  assign gate_if.resp_valid = respValid_q;
  assign gate_if.resp_gate  = respGate_q;
  assign gate_if.resp_ok    = respOk_q;
  assign hour_o             = hour_q;
  assign uni_cap_o          = uniCap_q;
  assign uni_parked_o       = uniParked_q;
  assign gen_parked_o       = CNT_W'(genParkedW);
  assign uni_free_o         = uniFree;
  assign gen_free_o         = genFree;
  assign uni_avail_o        = (uniFree != '0);
  assign gen_avail_o        = (genFree != '0);

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: directed scenarios followed by random traffic,
// all checked against an occupancy model built from the parking rules.
module tb_parking_gate_ctrl;

  localparam int NG     = 2;
  localparam int TOTAL  = 10;
  localparam int INITU  = 5;
  localparam int FINALU = 2;
  localparam int INC    = 1;
  localparam int SHRINK = 13;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hourTick = 1'b0;
  logic [4:0] hour;
  logic [3:0] uniCap, uniParked, genParked, uniFree, genFree;
  logic       uniAvail, genAvail;

  parking_gate_if #(.NUM_GATES(NG), .GW(1)) gif ();

  parking_gate_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hour_tick_i  (hourTick),
    .gate_if      (gif),
    .hour_o       (hour),
    .uni_cap_o    (uniCap),
    .uni_parked_o (uniParked),
    .gen_parked_o (genParked),
    .uni_free_o   (uniFree),
    .gen_free_o   (genFree),
    .uni_avail_o  (uniAvail),
    .gen_avail_o  (genAvail)
  );

  always #5 clk = ~clk;

  typedef struct { int gate; int ok; } resp_t;
  resp_t expQ[$];

  int checks = 0;
  int errors = 0;
  int mHour, mUniPark, mNonuni, mOvf, mPtr, lastGrant;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int capForHour(input int h);
    int c;
    if (h <= SHRINK) return INITU;
    c = INITU - INC * (h - SHRINK);
    return (c > FINALU) ? c : FINALU;
  endfunction

  function automatic int modelUniFree();
    int cap = capForHour(mHour);
    return (cap > mUniPark) ? cap - mUniPark : 0;
  endfunction

  function automatic int modelGenFree();
    int cap = capForHour(mHour);
    int f   = TOTAL - ((cap > mUniPark) ? cap : mUniPark) - mNonuni - mOvf;
    return (f > 0) ? f : 0;
  endfunction

  function automatic int decide(input logic entry, input logic uni);
    if (entry && uni) begin
      if (modelUniFree() > 0) begin mUniPark++; return 1; end
      if (modelGenFree() > 0) begin mOvf++; return 1; end
      return 0;
    end else if (entry) begin
      if (modelGenFree() > 0) begin mNonuni++; return 1; end
      return 0;
    end else if (uni) begin
      if (mOvf > 0) begin mOvf--; return 1; end
      if (mUniPark > 0) begin mUniPark--; return 1; end
      return 0;
    end
    if (mNonuni > 0) begin mNonuni--; return 1; end
    return 0;
  endfunction

  task automatic modelReset();
    mHour = 0; mUniPark = 0; mNonuni = 0; mOvf = 0; mPtr = 0; lastGrant = -1;
    expQ.delete();
  endtask

  task automatic checkStatus();
    checkOutput("hour", hour, mHour);
    checkOutput("uni_cap", uniCap, capForHour(mHour));
    checkOutput("uni_parked", uniParked, mUniPark);
    checkOutput("gen_parked", genParked, mNonuni + mOvf);
    checkOutput("uni_free", uniFree, modelUniFree());
    checkOutput("gen_free", genFree, modelGenFree());
    checkOutput("uni_avail", uniAvail, modelUniFree() != 0);
    checkOutput("gen_avail", genAvail, modelGenFree() != 0);
  endtask

  // One cycle: check state, drive inputs, predict the grant and queue its response.
  task automatic applyStimulus(input logic [NG-1:0] v, input logic [NG-1:0] e,
                               input logic [NG-1:0] u, input logic tick);
    int g = -1;
    int ok;
    @(negedge clk);
    checkStatus();
    gif.req_valid = v;
    gif.req_entry = e;
    gif.req_uni   = u;
    hourTick      = tick;
    #1;
    for (int i = 0; i < NG; i++) begin
      int idx = (mPtr + i) % NG;
      if (g < 0 && v[idx]) g = idx;
    end
    checkOutput("req_ready", gif.req_ready, (g >= 0) ? (1 << g) : 0);
    lastGrant = g;
    if (g >= 0) begin
      ok = decide(e[g], u[g]);
      expQ.push_back('{g, ok});
      mPtr = (g + 1) % NG;
    end
    if (tick) mHour = (mHour + 1) % 24;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    gif.req_valid = '0;
    hourTick = 1'b0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    resp_t r;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        checkOutput("resp_valid", gif.resp_valid, expQ.size() > 0);
        if (gif.resp_valid && expQ.size() > 0) begin
          r = expQ.pop_front();
          checkOutput("resp_gate", gif.resp_gate, r.gate);
          checkOutput("resp_ok", gif.resp_ok, r.ok);
        end
      end
    end
  end

  initial begin : driver
    logic [NG-1:0] v, e, u;
    gif.req_valid = '0;
    gif.req_entry = '0;
    gif.req_uni   = '0;
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] reset asserted during a grant");
    applyStimulus(2'b01, 2'b01, 2'b01, 1'b0);
    #2;
    rst_n = 1'b0;
    modelReset();
    gif.req_valid = '0;
    #1;
    checkOutput("resp_valid_in_reset", gif.resp_valid, 0);
    @(posedge clk);
    #2;
    checkOutput("resp_valid_after_reset_edge", gif.resp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);

    $display("[TB] fill with uni then non-uni cars");
    repeat (6) applyStimulus(2'b01, 2'b01, 2'b01, 1'b0);
    repeat (5) applyStimulus(2'b10, 2'b10, 2'b00, 1'b0);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);

    $display("[TB] uni exit with overflow, then non-uni exit when empty");
    applyStimulus(2'b01, 2'b00, 2'b01, 1'b0);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);
    doReset();
    applyStimulus(2'b10, 2'b00, 2'b00, 1'b0);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);

    $display("[TB] shrink schedule with stranded uni cars");
    doReset();
    repeat (5) applyStimulus(2'b01, 2'b01, 2'b01, 1'b0);
    repeat (16) applyStimulus(2'b00, 2'b00, 2'b00, 1'b1);
    applyStimulus(2'b10, 2'b10, 2'b00, 1'b0);
    repeat (8) applyStimulus(2'b00, 2'b00, 2'b00, 1'b1);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);

    $display("[TB] round-robin with both gates valid");
    doReset();
    repeat (4) applyStimulus(2'b11, 2'b11, 2'b01, 1'b0);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);

    $display("[TB] random traffic");
    v = '0; e = '0; u = '0;
    for (int c = 0; c < 400; c++) begin
      for (int g = 0; g < NG; g++) begin
        if (!v[g]) begin
          v[g] = ($urandom_range(0, 2) != 0);
          e[g] = ($urandom_range(0, 9) < 6);
          u[g] = $urandom_range(0, 1);
        end
      end
      applyStimulus(v, e, u, $urandom_range(0, 9) == 0);
      if (lastGrant >= 0) v[lastGrant] = 1'b0;
    end
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
